bm_if_reset_pipe: RTL and testbench

BM_IF_RESET_PIPE -- requirements
Module: bm_if_reset_pipe

---
 rtl/bm_if_reset_pipe_pkg.sv | 15 +
 rtl/bm_if_reset_pipe_if.sv | 28 ++
 rtl/bm_if_reset_pipe_stage.sv | 31 +++
 rtl/bm_if_reset_pipe.sv | 101 ++++++++++
 tb/tb_bm_if_reset_pipe.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bm_if_reset_pipe_pkg.sv
// Shared constants for the bm_if_reset pipeline: operation encodings and the
// width and saturation value of the completed-output counter.
package bm_if_reset_pkg;

  typedef enum logic [1:0] {
    MODE_AND = 2'b00,
    MODE_INV = 2'b01,
    MODE_XOR = 2'b10,
    MODE_OR  = 2'b11
  } mode_e;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/bm_if_reset_pipe_if.sv
// Operand/result handshake bundle for bm_if_reset_pipe; the slave side is the
// pipeline, the master side is whoever feeds and drains it.
interface bm_if_reset_pipe_if #(
  parameter int WIDTH = 2
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             d_in;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out0;
  logic             out1;
  logic             busy;

  modport slave (
    input  in_valid, a_in, b_in, c_in, d_in, mode, out_ready,
    output in_ready, out_valid, out0, out1, busy
  );

  modport master (
    output in_valid, a_in, b_in, c_in, d_in, mode, out_ready,
    input  in_ready, out_valid, out0, out1, busy
  );
endinterface

// File: rtl/bm_if_reset_pipe_stage.sv
// One pipeline register: valid flag plus result payload, cleared asynchronously.
// Payload only loads alongside a valid entry so idle bubbles leave it untouched.
module bm_if_reset_stage #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] out0_d,
  input  logic             out1_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] out0_q,
  output logic             out1_q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      out0_q  <= '0;
      out1_q  <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      if (valid_d) begin
        out0_q <= out0_d;
        out1_q <= out1_d;
      end
    end
  end

endmodule

// File: rtl/bm_if_reset_pipe.sv
// Elastic DEPTH-stage logic pipeline with valid/ready on both ends.
// Optional saturating retire counter enabled by BM_IF_RESET_PIPE_CNT_EN.
module bm_if_reset_pipe
  import bm_if_reset_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  bm_if_reset_pipe_if.slave   bus
`ifdef BM_IF_RESET_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0]    count
`endif
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] advance;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] flag_q;
  logic [DEPTH-1:0] vin;
  logic [WIDTH-1:0] din [DEPTH];
  logic [DEPTH-1:0] fin;
  logic [WIDTH-1:0] op0;
  logic             op1;

  always_comb begin
    op0 = '0;
    op1 = bus.c_in & bus.d_in;
    case (bus.mode)
      MODE_AND: op0 = bus.a_in & bus.b_in;
      MODE_INV: op0 = ~bus.a_in;
      MODE_XOR: op0 = bus.a_in ^ bus.b_in;
      MODE_OR:  op0 = bus.a_in | bus.b_in;
      default:  op0 = '0;
    endcase
  end

  // Backpressure ripples from the output toward stage 0 within the cycle.
  always_comb begin
    advance = '0;
    advance[DEPTH-1] = !valid_q[DEPTH-1] || bus.out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      advance[k] = !valid_q[k] || advance[k+1];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign vin[gi] = bus.in_valid;
      assign din[gi] = op0;
      assign fin[gi] = op1;
    end else begin : g_body
      assign vin[gi] = valid_q[gi-1];
      assign din[gi] = data_q[gi-1];
      assign fin[gi] = flag_q[gi-1];
    end

    bm_if_reset_stage #(.WIDTH(WIDTH)) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (advance[gi]),
      .valid_d (vin[gi]),
      .out0_d  (din[gi]),
      .out1_d  (fin[gi]),
      .valid_q (valid_q[gi]),
      .out0_q  (data_q[gi]),
      .out1_q  (flag_q[gi])
    );
  end

  assign bus.in_ready  = !valid_q[0] || advance[0];
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out0      = data_q[DEPTH-1];
  assign bus.out1      = flag_q[DEPTH-1];
  assign bus.busy      = |valid_q;

`ifdef BM_IF_RESET_PIPE_CNT_EN
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (valid_q[DEPTH-1] && bus.out_ready && (count_q != CNT_SAT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_bm_if_reset_pipe.sv
// Scoreboard bench for bm_if_reset_pipe: accepted operands push a model result,
// a separate monitor pops on every output handshake and compares.
module tb_bm_if_reset_pipe;
  import bm_if_reset_pkg::*;

  localparam int W = 2;
  localparam int D = 3;

  typedef struct packed {
    logic [W-1:0] o0;
    logic         o1;
  } res_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bm_if_reset_pipe_if #(.WIDTH(W)) bus ();

`ifdef BM_IF_RESET_PIPE_CNT_EN
  logic [15:0] count;
  bm_if_reset_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .count(count));
`else
  bm_if_reset_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));
`endif

  int   checks = 0;
  int   errors = 0;
  int   retired = 0;
  res_t exp_q[$];
  res_t ret_q[$];
  logic stall_prev = 1'b0;
  res_t stall_val;

  // Reference: the operation table written out with plain integer arithmetic.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic d, input logic [1:0] m);
    res_t res;
    int   r;
    int   ai;
    int   bi;
    ai = int'(a);
    bi = int'(b);
    r  = 0;
    for (int i = 0; i < W; i++) begin
      int abit;
      int bbit;
      int obit;
      abit = (ai >> i) % 2;
      bbit = (bi >> i) % 2;
      case (m)
        2'd0:    obit = abit * bbit;
        2'd1:    obit = 1 - abit;
        2'd2:    obit = (abit + bbit) % 2;
        default: obit = (abit + bbit > 0) ? 1 : 0;
      endcase
      r = r + (obit << i);
    end
    res.o0 = r[W-1:0];
    res.o1 = c & d;
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // Input side of the scoreboard.
  initial forever begin
    @(negedge clock);
    if (reset_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.a_in, bus.b_in, bus.c_in, bus.d_in, bus.mode));
  end

  // Output side: pop on handshake, and demand stable outputs while stalled.
  initial forever begin
    res_t e;
    @(negedge clock);
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'({bus.out0, bus.out1}), 32'(stall_val));
      end
      if (bus.out_valid && bus.out_ready) begin
        retired++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h required=none", {bus.out0, bus.out1});
        end else begin
          e = exp_q.pop_front();
          chk("sb_out0", 32'(bus.out0), 32'(e.o0));
          chk("sb_out1", 32'(bus.out1), 32'(e.o1));
        end
        ret_q.push_back({bus.out0, bus.out1});
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_val  = {bus.out0, bus.out1};
    end
  end

  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic d, input logic [1:0] m);
    bus.in_valid = 1'b1;
    bus.a_in = a;
    bus.b_in = b;
    bus.c_in = c;
    bus.d_in = d;
    bus.mode = m;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic d, input logic [1:0] m);
    int n;
    set_in(a, b, c, d, m);
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) timeout("send_accept");
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0 || bus.busy) timeout("drain");
    @(posedge clock);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.c_in = 1'b0;
    bus.d_in = 1'b0;
    bus.mode = 2'b00;
    bus.out_ready = 1'b0;

    // Reset state while reset_n is low, then release between edges.
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out0", 32'(bus.out0), 32'd0);
    chk("rst_out1", 32'(bus.out1), 32'd0);
`ifdef BM_IF_RESET_PIPE_CNT_EN
    chk("rst_count", 32'(count), 32'd0);
`endif
    #10;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;

    // Latency: result appears exactly D cycles after acceptance.
    bus.out_ready = 1'b1;
    ret_q.delete();
    send(2'b11, 2'b01, 1'b1, 1'b1, 2'b00);
    bus.in_valid = 1'b0;
    for (int i = 1; i <= D; i++) begin
      @(negedge clock);
      chk("lat_valid", 32'(bus.out_valid), 32'(i == D));
    end
    chk("lat_out0", 32'(bus.out0), 32'd1);
    chk("lat_out1", 32'(bus.out1), 32'd1);
    @(posedge clock);
    #1;

    // Remaining modes back to back, retired in order.
    ret_q.delete();
    send(2'b10, 2'b11, 1'b0, 1'b1, 2'b01);
    send(2'b10, 2'b11, 1'b1, 1'b0, 2'b10);
    send(2'b10, 2'b11, 1'b1, 1'b1, 2'b11);
    drain();
    chk("modes_count", 32'(ret_q.size()), 32'd3);
    chk("mode_inv", 32'(ret_q[0].o0), 32'd1);
    chk("mode_xor", 32'(ret_q[1].o0), 32'd1);
    chk("mode_or", 32'(ret_q[2].o0), 32'd3);

    // Fill with out_ready low until backpressure, then accept+retire together.
    ret_q.delete();
    bus.out_ready = 1'b0;
    for (int k = 0; k < D; k++) begin
      set_in(W'(k), W'(k + 1), 1'b1, 1'(k), 2'(k));
      @(negedge clock);
      chk("fill_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clock);
      #1;
    end
    set_in(2'b01, 2'b10, 1'b1, 1'b1, 2'b10);
    @(negedge clock);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_busy", 32'(bus.busy), 32'd1);
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("full_ready2", 32'(bus.in_ready), 32'd0);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("swap_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
    set_in(2'b11, 2'b00, 1'b0, 1'b0, 2'b01);
    @(negedge clock);
    chk("swap_busy", 32'(bus.busy), 32'd1);
    chk("swap_valid", 32'(bus.out_valid), 32'd1);
    chk("swap_ready2", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
    drain();
    chk("stall_count", 32'(ret_q.size()), 32'd5);

    // Asynchronous reset with results in flight.
    bus.out_ready = 1'b0;
    send(2'b11, 2'b10, 1'b1, 1'b1, 2'b11);
    send(2'b01, 2'b01, 1'b1, 1'b1, 2'b00);
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_out0", 32'(bus.out0), 32'd0);
    chk("arst_out1", 32'(bus.out1), 32'd0);
    exp_q.delete();
    retired = 0;
    bus.out_ready = 1'b1;
    #9;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
`ifdef BM_IF_RESET_PIPE_CNT_EN
    chk("post_rst_count", 32'(count), 32'd0);
`endif
    @(posedge clock);
    #1;

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.a_in      = W'($urandom);
      bus.b_in      = W'($urandom);
      bus.c_in      = 1'($urandom);
      bus.d_in      = 1'($urandom);
      bus.mode      = 2'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clock);
      #1;
    end
    drain();

`ifdef BM_IF_RESET_PIPE_CNT_EN
    chk("count_track", 32'(count), 32'(retired));
    set_in(2'b10, 2'b01, 1'b1, 1'b0, 2'b11);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clock);
    end
    #1;
    @(negedge clock);
    chk("count_sat", 32'(count), 32'hFFFF);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("count_hold", 32'(count), 32'hFFFF);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
